wb_reg_stream: RTL and testbench



---
 rtl/wb_reg_stream.sv | 178 +++++++++++++++++
 tb/tb_wb_reg_stream.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_stream.sv
// Pipelined Wishbone-style slave: control/status/scratch registers plus a 16-deep streaming FIFO.
// Define WB_REG_STREAM_IRQ_EN to add the THRESH register (0x04) and the irq_o output.
module wb_reg_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MSB   = WIDTH - 1,
  parameter int unsigned ASB   = WIDTH - 2,
  parameter int unsigned FBITS = 4,
  parameter int unsigned DELAY = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           cyc_i,
  input  logic           stb_i,
  input  logic           we_i,
  output logic           ack_o,
  input  logic [ASB:0]   adr_i,
  input  logic [MSB:0]   dat_i,
  output logic [MSB:0]   dat_o,
  input  logic           s_stb_i,
  input  logic [MSB:0]   s_dat_i,
  output logic           s_rdy_o,
  output logic           enable_o,
  output logic           overflow_o
`ifdef WB_REG_STREAM_IRQ_EN
  ,
  output logic           irq_o
`endif
);

  localparam int unsigned Depth = 1 << FBITS;
  localparam logic [FBITS:0] FullCount = {1'b1, {FBITS{1'b0}}};
  localparam logic [ASB:0] AdrCtrl    = 0;
  localparam logic [ASB:0] AdrStatus  = 1;
  localparam logic [ASB:0] AdrStream  = 2;
  localparam logic [ASB:0] AdrScratch = 3;

  // DELAY only matters to zero-delay-averse simulators; registers here use plain NBAs.
  if ((WIDTH != 8) || (MSB != WIDTH - 1) || (ASB != WIDTH - 2) || (FBITS < 1) || (FBITS > 4)
      || (DELAY > 1000)) begin : gen_param_check
    $error("wb_reg_stream: unsupported parameter set");
  end

  logic           ack_q, ack_d;
  logic [MSB:0]   dat_q, dat_d;
  logic           enable_q, enable_d;
  logic [MSB:0]   scratch_q, scratch_d;
  logic           ovf_q, ovf_d;
  logic           udr_q, udr_d;
  logic [FBITS:0] count_q, count_d;
  logic [FBITS:0] rptr_q, rptr_d;
  logic [FBITS:0] wptr_q, wptr_d;
  logic [MSB:0]   mem_q [Depth];

  logic req, rd_req, wr_req, empty, full, pop, push, clear, ovf_set, udr_set;
  logic [MSB:0] rdata, status;

`ifdef WB_REG_STREAM_IRQ_EN
  localparam logic [ASB:0] AdrThresh = 4;
  logic [FBITS:0] thresh_q, thresh_d;
  logic           irq_q, irq_d;
`endif

  assign req     = cyc_i & stb_i;
  assign rd_req  = req & ~we_i;
  assign wr_req  = req & we_i;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  assign status  = {empty, ovf_q, udr_q, 5'(count_q)};

  assign pop     = rd_req && (adr_i == AdrStream) && !empty;
  assign udr_set = rd_req && (adr_i == AdrStream) && empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
  assign push    = s_stb_i && enable_q && (!full || pop);
  assign ovf_set = s_stb_i && enable_q && full && !pop;
  assign clear   = wr_req && (adr_i == AdrCtrl) && dat_i[7];

  always_comb begin
    rdata = '0;
    case (adr_i)
      AdrCtrl:    rdata = {{(WIDTH - 1){1'b0}}, enable_q};
      AdrStatus:  rdata = status;
      AdrStream:  rdata = empty ? '0 : mem_q[rptr_q[FBITS-1:0]];
      AdrScratch: rdata = scratch_q;
`ifdef WB_REG_STREAM_IRQ_EN
      AdrThresh:  rdata = WIDTH'(thresh_q);
`endif
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    ack_d     = req;
    dat_d     = rd_req ? rdata : dat_q;
    enable_d  = enable_q;
    scratch_d = scratch_q;
    ovf_d     = ovf_q;
    udr_d     = udr_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;

    if (wr_req && (adr_i == AdrCtrl))    enable_d  = dat_i[0];
    if (wr_req && (adr_i == AdrScratch)) scratch_d = dat_i;
    if (wr_req && (adr_i == AdrStatus)) begin
      if (dat_i[6]) ovf_d = 1'b0;
      if (dat_i[5]) udr_d = 1'b0;
    end
    // Set events are applied after the W1C so they win a same-cycle race.
    if (ovf_set) ovf_d = 1'b1;
    if (udr_set) udr_d = 1'b1;

    if (clear) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      enable_q  <= 1'b0;
      scratch_q <= '0;
      ovf_q     <= 1'b0;
      udr_q     <= 1'b0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      enable_q  <= enable_d;
      scratch_q <= scratch_d;
      ovf_q     <= ovf_d;
      udr_q     <= udr_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear) mem_q[wptr_q[FBITS-1:0]] <= s_dat_i;
  end

`ifdef WB_REG_STREAM_IRQ_EN
  always_comb begin
    thresh_d = thresh_q;
    if (wr_req && (adr_i == AdrThresh)) thresh_d = dat_i[FBITS:0];
    irq_d = (enable_q && (count_q >= thresh_q) && (thresh_q != '0)) || ovf_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      thresh_q <= FBITS'(1) << 3;
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o = irq_q;
`endif

  assign ack_o      = ack_q;
  assign dat_o      = dat_q;
  assign s_rdy_o    = enable_q & ~full;
  assign enable_o   = enable_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_wb_reg_stream.sv
// Self-checking bench for wb_reg_stream: directed register/FIFO scenarios, then random traffic
// checked every cycle against a queue-based reference model.
module tb_wb_reg_stream;

  logic       clk = 1'b0;
  logic       rst, cyc, stb, we, ack;
  logic [6:0] adr;
  logic [7:0] dat_w, dat_r, s_dat;
  logic       s_stb, s_rdy, enable, overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] m_fifo[$];
  bit         m_en, m_ovf, m_udr, m_ack;
  logic [7:0] m_scr, m_dat;

  always #5 clk = ~clk;

  wb_reg_stream dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cyc_i      (cyc),
    .stb_i      (stb),
    .we_i       (we),
    .ack_o      (ack),
    .adr_i      (adr),
    .dat_i      (dat_w),
    .dat_o      (dat_r),
    .s_stb_i    (s_stb),
    .s_dat_i    (s_dat),
    .s_rdy_o    (s_rdy),
    .enable_o   (enable),
    .overflow_o (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_fifo.size() == 0, m_ovf, m_udr, 5'(m_fifo.size())};
  endfunction

  // One bus clock: drive inputs, advance the model, then compare all outputs after the edge.
  task automatic tick(input logic r, input logic c, input logic s, input logic w,
                      input logic [6:0] a, input logic [7:0] d, input logic ss,
                      input logic [7:0] sd);
    bit req, rd, wr, do_pop, do_push, set_ovf, set_udr;
    rst = r; cyc = c; stb = s; we = w; adr = a; dat_w = d; s_stb = ss; s_dat = sd;
    if (r) begin
      m_fifo.delete();
      m_en = 0; m_ovf = 0; m_udr = 0; m_ack = 0; m_scr = 8'h00; m_dat = 8'h00;
    end else begin
      req = c && s;
      rd  = req && !w;
      wr  = req && w;
      if (rd) begin
        case (a)
          7'h00:   m_dat = {7'b0, m_en};
          7'h01:   m_dat = m_status();
          7'h02:   m_dat = (m_fifo.size() > 0) ? m_fifo[0] : 8'h00;
          7'h03:   m_dat = m_scr;
          default: m_dat = 8'h00;
        endcase
      end
      do_pop  = rd && (a == 7'h02) && (m_fifo.size() > 0);
      set_udr = rd && (a == 7'h02) && (m_fifo.size() == 0);
      do_push = 0;
      set_ovf = 0;
      if (ss && m_en) begin
        if (m_fifo.size() < 16 || do_pop) do_push = 1;
        else set_ovf = 1;
      end
      if (wr && a == 7'h00 && d[7]) m_fifo.delete();
      else begin
        if (do_pop) void'(m_fifo.pop_front());
        if (do_push) m_fifo.push_back(sd);
      end
      if (wr && a == 7'h01) begin
        if (d[6]) m_ovf = 0;
        if (d[5]) m_udr = 0;
      end
      if (set_ovf) m_ovf = 1;
      if (set_udr) m_udr = 1;
      if (wr && a == 7'h00) m_en = d[0];
      if (wr && a == 7'h03) m_scr = d;
      m_ack = req;
    end
    @(posedge clk);
    #1;
    check_eq("ack", ack, m_ack);
    check_eq("dat_o", dat_r, m_dat);
    check_eq("s_rdy", s_rdy, m_en && (m_fifo.size() < 16));
    check_eq("enable", enable, m_en);
    check_eq("overflow", overflow, m_ovf);
  endtask

  task automatic bus_wr(input logic [6:0] a, input logic [7:0] d);
    tick(0, 1, 1, 1, a, d, 0, 8'h00);
  endtask

  task automatic rd_expect(input string tag, input logic [6:0] a, input logic [7:0] exp);
    tick(0, 1, 1, 0, a, 8'h00, 0, 8'h00);
    check_eq(tag, dat_r, exp);
  endtask

  task automatic push(input logic [7:0] d);
    tick(0, 0, 0, 0, 7'h00, 8'h00, 1, d);
  endtask

  initial begin
    logic [6:0] a;
    logic [7:0] d;
    logic       c, s, w, ss, r;
    int         sel;

    tick(1, 0, 0, 0, 7'h00, 8'h00, 0, 8'h00);
    tick(1, 0, 0, 0, 7'h00, 8'h00, 0, 8'h00);
    check_eq("rst_ack", ack, 0);

    rd_expect("rst_ctrl", 7'h00, 8'h00);
    rd_expect("rst_status", 7'h01, 8'h80);
    rd_expect("rst_scratch", 7'h03, 8'h00);

    bus_wr(7'h03, 8'h5A);
    rd_expect("scratch", 7'h03, 8'h5A);
    bus_wr(7'h7F, 8'hFF);
    rd_expect("unmapped", 7'h7F, 8'h00);
    check_eq("unmapped_ack", ack, 1);

    // Strobe without cyc must be ignored.
    tick(0, 0, 1, 0, 7'h02, 8'h00, 0, 8'h00);
    check_eq("no_cyc_ack", ack, 0);

    bus_wr(7'h00, 8'h01);
    push(8'h11); push(8'h22); push(8'h33);
    rd_expect("status3", 7'h01, 8'h03);
    rd_expect("pop0", 7'h02, 8'h11);
    rd_expect("pop1", 7'h02, 8'h22);
    rd_expect("pop2", 7'h02, 8'h33);
    rd_expect("status_empty", 7'h01, 8'h80);

    for (int i = 0; i < 17; i++) begin
      push(8'(i));
      if (i == 14) check_eq("rdy_before_full", s_rdy, 1);
      if (i == 15) check_eq("rdy_full", s_rdy, 0);
    end
    rd_expect("status_full_ovf", 7'h01, 8'h50);
    for (int i = 0; i < 16; i++) rd_expect("drain", 7'h02, 8'(i));

    rd_expect("underrun_data", 7'h02, 8'h00);
    rd_expect("status_udr", 7'h01, 8'hE0);
    bus_wr(7'h01, 8'h60);
    rd_expect("status_w1c", 7'h01, 8'h80);

    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    tick(0, 1, 1, 1, 7'h00, 8'h81, 1, 8'hEE);
    rd_expect("status_cleared", 7'h01, 8'h80);

    push(8'h01); push(8'h02);
    tick(1, 1, 1, 0, 7'h02, 8'h00, 0, 8'h00);
    check_eq("rst_mid_ack", ack, 0);
    rd_expect("status_after_rst", 7'h01, 8'h80);
    bus_wr(7'h00, 8'h01);

    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom % 600) == 0;
      c   = ($urandom % 8) != 0;
      s   = ($urandom % 4) != 0;
      w   = ($urandom % 3) == 0;
      sel = $urandom % 8;
      case (sel)
        0, 1, 2, 3: a = 7'(sel);
        4:          a = 7'h02;
        5:          a = 7'h01;
        6:          a = 7'h04;
        default:    a = 7'($urandom);
      endcase
      d = 8'($urandom);
      if (w && a == 7'h00) d = {($urandom % 24) == 0, 6'($urandom), ($urandom % 6) != 0};
      ss = ($urandom % 2) != 0;
      tick(r, c, s, w, a, d, ss, 8'($urandom));
    end

    tick(0, 0, 0, 0, 7'h00, 8'h00, 0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
